fwd_hazard_ctrl: RTL
====================

Name: fwd_hazard_ctrl

Overview:
Parametrised operand-forwarding and load-use hazard controller for the RV32 in-order pipeline. It sits between ID and EXE and keeps an internal scoreboard of in-flight destination registers, one entry per forwarding stage. For each source port it selects the youngest in-flight producer, or the register-file value when there is none, and raises a stall when a load result is not yet available. It generalises the fixed two-port EX/MEM bypass to N read ports, configurable forwarding depth and configurable load latency, and adds flush handling and performance counters.

Parameters:
NUM_RD_PORTS, 2, number of source operand ports (1..4)
NUM_FWD_STAGES, 2, in-flight stages tracked after ID; stage 0 = EXE, stage 1 = MEM, ... (1..4)
LOAD_LAT, 1, lowest stage index at which load data is valid on stage_data_i (0..NUM_FWD_STAGES-1)
XLEN, 32, datapath width
CNT_W, 16, performance counter width

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
issue_valid_i  in  1  ID holds an instruction requesting advance to EXE
issue_rd_i  in  5  destination register of the ID instruction
issue_wr_en_i  in  1  ID instruction writes rd
issue_is_load_i  in  1  ID instruction is a load
flush_i  in  1  kill the ID instruction (taken branch/jump)
src_addr_i  in  NUM_RD_PORTS*5  source register indices, port p at [5p+4:5p]
src_used_i  in  NUM_RD_PORTS  port p reads a register
rf_data_i  in  NUM_RD_PORTS*XLEN  register-file read data per port
stage_data_i  in  NUM_FWD_STAGES*XLEN  result value at stage k (stage MEM already muxes load data)
operand_o  out  NUM_RD_PORTS*XLEN  resolved operand per port
fwd_sel_o  out  NUM_RD_PORTS*3  per port: 0 = register file, k+1 = forwarded from stage k
stall_o  out  1  hold ID/IF and insert a bubble into EXE
issue_accept_o  out  1  the ID instruction entered EXE this cycle
stall_cnt_o  out  CNT_W  stall cycles, saturating
fwd_cnt_o  out  CNT_W  accepted-issue cycles with at least one forwarded port, saturating

Behaviour:
- Reset is asynchronous and active-high. Clock is clk_i; reset is reset_i, as throughout the core.
- Reset clears all scoreboard entries (valid = 0) and both counters. With no entries, stall_o = 0 and operand_o = rf_data_i, fwd_sel_o = 0 whenever issue_valid_i = 0.
- Scoreboard: entry[k] = {valid, rd, is_load}, k = 0..NUM_FWD_STAGES-1. It shifts every cycle with no global stall: entry[k] <= entry[k-1].
- entry[0] <= {issue_accept_o & issue_wr_en_i & (issue_rd_i != 0), issue_rd_i, issue_is_load_i}. A non-accepted cycle inserts a bubble (valid = 0).
- Match for port p: src_used_i[p], src_addr != 0, entry[k].valid and entry[k].rd == src_addr. Among matches, the lowest k (youngest) wins.
- Port p resolves (combinational, zero latency) as follows:
  - winner k with !(is_load && k < LOAD_LAT): operand = stage_data_i[k], fwd_sel = k+1.
  - no winner: operand = rf_data_i[p], fwd_sel = 0. The register file is write-before-read, so the writeback stage needs no bypass here.
  - winner is a load with k < LOAD_LAT: port hazard; operand = rf_data_i[p], fwd_sel = 0 (don't-care).
- stall_o = issue_valid_i & !flush_i & (any port hazard). Stall is combinational from the current scoreboard.
- issue_accept_o = issue_valid_i & !stall_o & !flush_i.
- A load-use hazard resolves after LOAD_LAT - k bubbles, because the producer shifts one stage per cycle. A younger non-load match on the same register masks an older load.
- flush_i has priority over stall: it forces stall_o = 0 and issue_accept_o = 0, and inserts a bubble. In-flight entries are not killed.
- Multiple ports may hit the same or different stages in the same cycle; each port is resolved independently.
- stall_cnt_o increments on every cycle with stall_o = 1. fwd_cnt_o increments on every cycle with issue_accept_o = 1 and any fwd_sel != 0. Both saturate at all-ones and never wrap.
- Reset asserted mid-stall clears the scoreboard immediately; stall_o drops in the same cycle.

Decomposition:
- Package fwd_pkg: sb_entry_t struct {valid, rd[4:0], is_load}; FWD_SEL_RF = 0; REG_X0 = 5'd0; sat_inc function.
- One sub-module, fwd_port_resolve: per-port priority match, mux and hazard flag. Instantiate it NUM_RD_PORTS times with a generate loop.
- The scoreboard shift register and the counters live in the top module.

Test Plan:
- Back-to-back ALU dependency: issue rd=5 (wr_en), next cycle src0=5 with stage_data_i[0]=0x1234 -> fwd_sel0=1, operand0=0x1234, no stall, fwd_cnt_o=1.
- Load-use with LOAD_LAT=1: load rd=7, next cycle src1=7 -> stall_o=1 for exactly 1 cycle. Following cycle fwd_sel1=2, operand1=stage_data_i[1]=0xCAFE, accept=1, stall_cnt_o=1.
- Priority: rd=3 issued twice consecutively, with stage0=0xA and stage1=0xB -> src0=3 gives operand 0xA and fwd_sel 1. x0 source with an x0 writer in flight -> fwd_sel=0, operand=rf_data.
- Flush during stall: load rd=9, dependent issue with flush_i=1 -> stall_o=0, accept=0, bubble inserted, stall_cnt_o unchanged.
- Parametrised NUM_RD_PORTS=3, NUM_FWD_STAGES=3, LOAD_LAT=2: load rd=4, then dependent -> 2 stall cycles, then fwd_sel=3. A third port hitting stage 0 simultaneously -> fwd_sel=1.
- Counter saturation with CNT_W=4: 20 stall cycles -> stall_cnt_o=15. Asserting reset_i mid-stall -> counters 0 and stall_o=0 without waiting for a clock edge.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the operand-forwarding / load-use hazard controller.
package fwd_pkg;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } sb_entry_t;

    localparam logic [2:0] FWD_SEL_RF = 3'd0;
    localparam logic [4:0] REG_X0     = 5'd0;

    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
        return (val >= max) ? max : val + 32'd1;
    endfunction

endpackage

// File: rtl/fwd_port_resolve.sv
// One source port: pick the youngest in-flight producer, or flag a load-use hazard.
module fwd_port_resolve
    import fwd_pkg::*;
#(
    parameter int NUM_FWD_STAGES = 2,
    parameter int LOAD_LAT       = 1,
    parameter int XLEN           = 32
) (
    input  logic                                src_used,
    input  logic [4:0]                          src_addr,
    input  logic [XLEN-1:0]                     rf_data,
    input  sb_entry_t [NUM_FWD_STAGES-1:0]      sb,
    input  logic [NUM_FWD_STAGES-1:0][XLEN-1:0] stage_data,
    output logic [XLEN-1:0]                     operand,
    output logic [2:0]                          fwd_sel,
    output logic                                hazard
);

    always_comb begin
        operand = rf_data;
        fwd_sel = FWD_SEL_RF;
        hazard  = 1'b0;
        // Walk oldest to youngest so a younger match overrides an older one.
        for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
            if (src_used && (src_addr != REG_X0) && sb[k].valid && (sb[k].rd == src_addr)) begin
                if (sb[k].is_load && (k < LOAD_LAT)) begin
                    operand = rf_data;
                    fwd_sel = FWD_SEL_RF;
                    hazard  = 1'b1;
                end else begin
                    operand = stage_data[k];
                    fwd_sel = 3'(k + 1);
                    hazard  = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// ID/EXE forwarding and load-use stall controller with an in-flight destination scoreboard.
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int NUM_RD_PORTS   = 2,
    parameter int NUM_FWD_STAGES = 2,
    parameter int LOAD_LAT       = 1,
    parameter int XLEN           = 32,
    parameter int CNT_W          = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           issue_valid_i,
    input  logic [4:0]                     issue_rd_i,
    input  logic                           issue_wr_en_i,
    input  logic                           issue_is_load_i,
    input  logic                           flush_i,
    input  logic [NUM_RD_PORTS*5-1:0]      src_addr_i,
    input  logic [NUM_RD_PORTS-1:0]        src_used_i,
    input  logic [NUM_RD_PORTS*XLEN-1:0]   rf_data_i,
    input  logic [NUM_FWD_STAGES*XLEN-1:0] stage_data_i,
    output logic [NUM_RD_PORTS*XLEN-1:0]   operand_o,
    output logic [NUM_RD_PORTS*3-1:0]      fwd_sel_o,
    output logic                           stall_o,
    output logic                           issue_accept_o,
    output logic [CNT_W-1:0]               stall_cnt_o,
    output logic [CNT_W-1:0]               fwd_cnt_o
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    sb_entry_t [NUM_FWD_STAGES-1:0]      sb_q;
    sb_entry_t                           sb_new;
    logic [NUM_FWD_STAGES-1:0][XLEN-1:0] stage_data;
    logic [NUM_RD_PORTS-1:0][4:0]        src_addr;
    logic [NUM_RD_PORTS-1:0][XLEN-1:0]   rf_data;
    logic [NUM_RD_PORTS-1:0][XLEN-1:0]   operand;
    logic [NUM_RD_PORTS-1:0][2:0]        fwd_sel;
    logic [NUM_RD_PORTS-1:0]             hazard;
    logic [CNT_W-1:0]                    stall_cnt_q;
    logic [CNT_W-1:0]                    fwd_cnt_q;

    assign stage_data = stage_data_i;
    assign src_addr   = src_addr_i;
    assign rf_data    = rf_data_i;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        fwd_port_resolve #(
            .NUM_FWD_STAGES(NUM_FWD_STAGES),
            .LOAD_LAT      (LOAD_LAT),
            .XLEN          (XLEN)
        ) u_resolve (
            .src_used  (src_used_i[p]),
            .src_addr  (src_addr[p]),
            .rf_data   (rf_data[p]),
            .sb        (sb_q),
            .stage_data(stage_data),
            .operand   (operand[p]),
            .fwd_sel   (fwd_sel[p]),
            .hazard    (hazard[p])
        );
    end

    assign operand_o      = operand;
    assign fwd_sel_o      = fwd_sel;
    // Flush wins over stall: the killed instruction must not hold the front end.
    assign stall_o        = issue_valid_i & ~flush_i & (|hazard);
    assign issue_accept_o = issue_valid_i & ~flush_i & ~stall_o;

    assign sb_new = '{valid:   issue_accept_o & issue_wr_en_i & (issue_rd_i != REG_X0),
                      rd:      issue_rd_i,
                      is_load: issue_is_load_i};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sb_q <= '0;
        end else begin
            sb_q[0] <= sb_new;
            for (int k = 1; k < NUM_FWD_STAGES; k++) begin
                sb_q[k] <= sb_q[k-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall_o) begin
                stall_cnt_q <= CNT_W'(sat_inc(32'(stall_cnt_q), CNT_MAX));
            end
            if (issue_accept_o && (|fwd_sel)) begin
                fwd_cnt_q <= CNT_W'(sat_inc(32'(fwd_cnt_q), CNT_MAX));
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign fwd_cnt_o   = fwd_cnt_q;

endmodule
